// File: rtl/combo_lock_fsm_if.sv
// rtl/combo_lock_fsm_if.sv - keypad-side and indicator-side signals of the combination lock
interface combo_lock_fsm_if #(
    parameter int DIGIT_W    = 4,
    parameter int NUM_DIGITS = 3,
    parameter int MAX_TRIES  = 3
);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);

    logic               enter;
    logic [DIGIT_W-1:0] digit;
    logic               set_code;
    logic               unlocked;
    logic               alarm;
    logic               error;
    logic [IDX_W-1:0]   digit_idx;
    logic [FAIL_W-1:0]  fail_count;

    // Drives presses and the programming request, observes the indicators
    modport master (
        output enter, digit, set_code,
        input  unlocked, alarm, error, digit_idx, fail_count
    );

    // The lock controller itself
    modport slave (
        input  enter, digit, set_code,
        output unlocked, alarm, error, digit_idx, fail_count
    );
endinterface

// File: rtl/combo_lock_fsm.sv
// rtl/combo_lock_fsm.sv - combination lock with failed-attempt lockout and code reprogramming
module combo_lock_fsm #(
    parameter int                            DIGIT_W        = 4,
    parameter int                            NUM_DIGITS     = 3,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] CODE_INIT      = 12'h3A7,
    parameter int                            MAX_TRIES      = 3,
    parameter int                            LOCKOUT_CYCLES = 50000000
) (
    input logic                Clock,
    input logic                Resetn,
    combo_lock_fsm_if.slave    lk
);
    localparam int CODE_W = NUM_DIGITS * DIGIT_W;
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);
    localparam int CNT_W  = $clog2(LOCKOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_PROGRAM = 2'd2,
        ST_ALARM   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                mis_q, mis_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [CODE_W-1:0]   shadow_q, shadow_d;
    logic                unlocked_q, unlocked_d;
    logic                alarm_q, alarm_d;
    logic                error_q, error_d;

    logic [DIGIT_W-1:0]  code_digit;
    logic [CODE_W-1:0]   shadow_wr;
    logic                mis_new;
    logic                last_digit;

    // Select the stored digit at the current position and build the shadow with the current digit merged in
    always_comb begin
        code_digit = '0;
        shadow_wr  = shadow_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                code_digit = code_q[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
                shadow_wr[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = lk.digit;
            end
        end
        mis_new    = mis_q | (lk.digit != code_digit);
        last_digit = (idx_q == IDX_W'(NUM_DIGITS - 1));
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mis_d    = mis_q;
        fail_d   = fail_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        shadow_d = shadow_q;
        error_d  = 1'b0;

        case (state_q)
            ST_ENTRY: begin
                if (lk.enter) begin
                    if (!last_digit) begin
                        idx_d = idx_q + IDX_W'(1);
                        mis_d = mis_new;
                    end else begin
                        idx_d = '0;
                        mis_d = 1'b0;
                        if (!mis_new) begin
                            state_d = ST_OPEN;
                            fail_d  = '0;
                        end else begin
                            error_d = 1'b1;
                            fail_d  = fail_q + FAIL_W'(1);
                            if (fail_q + FAIL_W'(1) == FAIL_W'(MAX_TRIES)) begin
                                state_d = ST_ALARM;
                                cnt_d   = CNT_W'(LOCKOUT_CYCLES - 1);
                            end
                        end
                    end
                end
            end
            ST_OPEN: begin
                if (lk.enter) begin
                    idx_d   = '0;
                    state_d = lk.set_code ? ST_PROGRAM : ST_ENTRY;
                end
            end
            ST_PROGRAM: begin
                // Dropping set_code wins over a press in the same cycle
                if (!lk.set_code) begin
                    state_d = ST_OPEN;
                    idx_d   = '0;
                end else if (lk.enter) begin
                    shadow_d = shadow_wr;
                    if (last_digit) begin
                        code_d  = shadow_wr;
                        state_d = ST_OPEN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_ALARM: begin
                idx_d = '0;
                if (cnt_q == '0) begin
                    state_d = ST_ENTRY;
                    fail_d  = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_ENTRY;
                idx_d   = '0;
                mis_d   = 1'b0;
            end
        endcase

        unlocked_d = (state_d == ST_OPEN) || (state_d == ST_PROGRAM);
        alarm_d    = (state_d == ST_ALARM);
    end

    // State and datapath registers
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= ST_ENTRY;
            idx_q      <= '0;
            mis_q      <= 1'b0;
            fail_q     <= '0;
            cnt_q      <= '0;
            code_q     <= CODE_INIT;
            shadow_q   <= '0;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mis_q      <= mis_d;
            fail_q     <= fail_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            shadow_q   <= shadow_d;
            unlocked_q <= unlocked_d;
            alarm_q    <= alarm_d;
            error_q    <= error_d;
        end
    end

    assign lk.unlocked   = unlocked_q;
    assign lk.alarm      = alarm_q;
    assign lk.error      = error_q;
    assign lk.digit_idx  = idx_q;
    assign lk.fail_count = fail_q;
endmodule

// File: tb/tb_combo_lock_fsm.sv
// tb/tb_combo_lock_fsm.sv - directed and random stimulus against a behavioural lock model
module tb_combo_lock_fsm;
    localparam int DIGIT_W = 4;
    localparam int NDIG    = 3;
    localparam int MAXT    = 3;
    localparam int LOCKC   = 8;
    localparam logic [11:0] CINIT = 12'h3A7;

    logic Clock = 1'b0;
    logic Resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    combo_lock_fsm_if #(.DIGIT_W(DIGIT_W), .NUM_DIGITS(NDIG), .MAX_TRIES(MAXT)) bus ();

    combo_lock_fsm #(
        .DIGIT_W(DIGIT_W), .NUM_DIGITS(NDIG), .CODE_INIT(CINIT),
        .MAX_TRIES(MAXT), .LOCKOUT_CYCLES(LOCKC)
    ) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .lk    (bus.slave)
    );

    always #5 Clock = ~Clock;

    // Behavioural model: combination as a list of numbers, presses collected in queues
    int  m_code[NDIG];
    int  m_entered[$];
    int  m_newcode[$];
    bit  m_open;
    bit  m_prog;
    int  m_lock_left;
    int  m_fails;
    bit  m_error;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_code[0] = 3; m_code[1] = 10; m_code[2] = 7;
        m_entered.delete();
        m_newcode.delete();
        m_open = 0; m_prog = 0; m_lock_left = 0; m_fails = 0; m_error = 0;
    endtask

    task automatic model_clock(input bit en, input int d, input bit sc);
        bit ok;
        m_error = 0;
        if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_fails = 0;
        end else if (m_prog) begin
            if (!sc) begin
                m_prog = 0;
                m_newcode.delete();
            end else if (en) begin
                m_newcode.push_back(d);
                if (m_newcode.size() == NDIG) begin
                    for (int i = 0; i < NDIG; i++) m_code[i] = m_newcode[i];
                    m_newcode.delete();
                    m_prog = 0;
                end
            end
        end else if (m_open) begin
            if (en) begin
                if (sc) begin
                    m_prog = 1;
                    m_newcode.delete();
                end else begin
                    m_open = 0;
                end
            end
        end else if (en) begin
            m_entered.push_back(d);
            if (m_entered.size() == NDIG) begin
                ok = 1;
                for (int i = 0; i < NDIG; i++) if (m_entered[i] != m_code[i]) ok = 0;
                m_entered.delete();
                if (ok) begin
                    m_open  = 1;
                    m_fails = 0;
                end else begin
                    m_error = 1;
                    m_fails++;
                    if (m_fails == MAXT) m_lock_left = LOCKC;
                end
            end
        end
    endtask

    task automatic check_all();
        int exp_idx;
        exp_idx = m_prog ? m_newcode.size() : ((m_open || m_lock_left > 0) ? 0 : m_entered.size());
        check("unlocked",   int'(bus.unlocked),   int'(m_open));
        check("alarm",      int'(bus.alarm),      int'(m_lock_left > 0));
        check("error",      int'(bus.error),      int'(m_error));
        check("digit_idx",  int'(bus.digit_idx),  exp_idx);
        check("fail_count", int'(bus.fail_count), m_fails);
    endtask

    // One clock: inputs already set up, model advances at the edge, outputs sampled 1ns later
    task automatic step(input bit en, input int d, input bit sc);
        bus.enter    = en;
        bus.digit    = 4'(d);
        bus.set_code = sc;
        @(posedge Clock);
        model_clock(en, d, sc);
        #1;
        check_all();
    endtask

    task automatic press(input int d, input bit sc);
        step(1'b1, d, sc);
        step(1'b0, 0, sc);
    endtask

    task automatic press3(input int a, input int b, input int c, input bit sc);
        press(a, sc);
        press(b, sc);
        press(c, sc);
    endtask

    // Reset asserted between edges; outputs must drop without a clock
    task automatic async_reset(input string tag);
        #2;
        Resetn = 1'b0;
        #1;
        check({tag, "_unlocked"},  int'(bus.unlocked),   0);
        check({tag, "_alarm"},     int'(bus.alarm),      0);
        check({tag, "_error"},     int'(bus.error),      0);
        check({tag, "_idx"},       int'(bus.digit_idx),  0);
        check({tag, "_fails"},     int'(bus.fail_count), 0);
        model_reset();
        bus.enter = 1'b0; bus.digit = '0; bus.set_code = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
    endtask

    initial begin
        int alarm_cycles;
        int d;
        bit sc;
        bus.enter = 1'b0; bus.digit = '0; bus.set_code = 1'b0;
        model_reset();
        #12;
        check_all();
        Resetn = 1'b1;
        @(negedge Clock);

        // Correct entry
        step(1, 3, 0);  check("t1_idx1", int'(bus.digit_idx), 1);
        step(1, 10, 0); check("t1_idx2", int'(bus.digit_idx), 2);
        step(1, 7, 0);  check("t1_open", int'(bus.unlocked), 1);
        press(0, 0);

        // Wrong first digit still takes three presses
        press(5, 0); press(10, 0);
        step(1, 7, 0);  check("t2_err", int'(bus.error), 1);
        step(0, 0, 0);  check("t2_err_pulse", int'(bus.error), 0);

        // Lockout after the third consecutive failure
        press3(1, 2, 3, 0);
        press(9, 0); press(9, 0);
        step(1, 9, 0);
        check("t3_fail3", int'(bus.fail_count), 3);
        alarm_cycles = 0;
        for (int i = 0; i < 30 && (bus.alarm || i == 0); i++) begin
            if (bus.alarm) alarm_cycles++;
            step(i[0], 3, 0);
        end
        check("t3_alarm_len", alarm_cycles, LOCKC);
        check("t3_fail_clr", int'(bus.fail_count), 0);
        press3(3, 10, 7, 0);
        check("t3_unlock", int'(bus.unlocked), 1);

        // Reprogram to 1,2,4
        press(0, 1);
        check("t4_prog_unl", int'(bus.unlocked), 1);
        press3(1, 2, 4, 1);
        press(0, 0);
        press3(3, 10, 7, 0);
        check("t4_old_fails", int'(bus.fail_count), 1);
        press3(1, 2, 4, 0);
        check("t4_new_open", int'(bus.unlocked), 1);

        // Reset restores the initial code
        async_reset("t6b");
        press3(3, 10, 7, 0);
        check("t6b_open", int'(bus.unlocked), 1);

        // Program abort keeps the old code
        press(0, 1);
        press(11, 1); press(12, 1);
        step(1, 13, 0);
        check("t5_abort_open", int'(bus.unlocked), 1);
        press(0, 0);
        press3(3, 10, 7, 0);
        check("t5_old_code", int'(bus.unlocked), 1);
        press(0, 0);

        // Reset in the middle of a lockout
        for (int k = 0; k < 3; k++) press3(0, 0, 0, 0);
        step(0, 0, 0); step(0, 0, 0);
        check("t6a_in_alarm", int'(bus.alarm), 1);
        async_reset("t6a");
        press3(3, 10, 7, 0);
        check("t6a_open", int'(bus.unlocked), 1);

        // Random traffic, digits biased toward the correct next value
        sc = 0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 19) == 0) sc = ~sc;
            if (!m_open && !m_prog && m_entered.size() < NDIG && $urandom_range(0, 9) < 7)
                d = m_code[m_entered.size()];
            else
                d = $urandom_range(0, 15);
            step(($urandom_range(0, 9) < 4), d, sc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/combo_lock_fsm.md
Name: combo_lock_fsm

Overview:
- Combination-lock controller directly downstream of the pushbutton conditioner.
- Consumes the conditioner's single-cycle "enter" pulse together with a switch-set digit and compares the digit sequence against a stored code.
- Drives unlock and alarm indicators, enforces a failed-attempt lockout, and lets the code be reprogrammed while unlocked.

Parameters:
DIGIT_W, 4, width of one code digit
NUM_DIGITS, 3, digits per combination (>=2)
CODE_INIT, 12'h3A7, reset-time code, NUM_DIGITS*DIGIT_W bits; digit 0 = most significant field
MAX_TRIES, 3, consecutive failed attempts that trigger lockout (>=1)
LOCKOUT_CYCLES, 50000000, clock cycles spent in lockout (>=2)

Ports:
Clock  in  1  system clock, rising edge
Resetn  in  1  asynchronous active-low reset
enter  in  1  one-cycle pulse from the conditioner; each high cycle counts as one press
digit  in  DIGIT_W  switch value, sampled only on cycles where enter=1
set_code  in  1  level; requests programming mode while unlocked
unlocked  out  1  registered; 1 in OPEN and PROGRAM
alarm  out  1  registered; 1 in ALARM
error  out  1  registered one-cycle pulse on each failed attempt
digit_idx  out  clog2(NUM_DIGITS)  index of the next digit expected
fail_count  out  clog2(MAX_TRIES+1)  consecutive failures

Behaviour:
- Reset (async, Resetn=0): state=ENTRY, digit_idx=0, mismatch flag=0, fail_count=0, lockout counter=0, code register=CODE_INIT, shadow register=0, unlocked=0, alarm=0, error=0. Reset during any state, including PROGRAM or ALARM, restores CODE_INIT.
- States: ENTRY, OPEN, PROGRAM, ALARM. Decisions are made at the clock edge that samples enter; outputs reflect the new state on the following cycle (latency 1).
- ENTRY:
  - On enter: mismatch |= (digit != code[digit_idx]).
  - If digit_idx < NUM_DIGITS-1: increment digit_idx.
  - Otherwise the attempt is evaluated using the mismatch value that includes the current digit:
    - Match: go to OPEN, fail_count=0.
    - Mismatch: error=1 for one cycle and fail_count+1. If the new fail_count equals MAX_TRIES, go to ALARM with counter=LOCKOUT_CYCLES-1; otherwise stay in ENTRY.
  - digit_idx and mismatch clear to 0 on every evaluation.
  - No early abort: a wrong first digit still requires NUM_DIGITS presses.
- OPEN:
  - enter with set_code=0: relock, go to ENTRY with digit_idx=0.
  - enter with set_code=1: go to PROGRAM with digit_idx=0. That press's digit is discarded.
  - No enter: hold.
- PROGRAM:
  - On enter: shadow[digit_idx] <= digit and increment digit_idx.
  - On the last digit: code <= shadow with the current digit merged in, go to OPEN, digit_idx=0.
  - If set_code=0 on any cycle: abort. Code is unchanged, go to OPEN, digit_idx=0. Abort takes priority over a simultaneous enter.
- ALARM:
  - alarm=1; enter is ignored (digit_idx stays 0).
  - Counter decrements each cycle. In the cycle it reads 0, go to ENTRY with fail_count=0.
  - Lockout lasts exactly LOCKOUT_CYCLES cycles of alarm=1.
- error never asserts outside ENTRY evaluations. unlocked and alarm are never both 1.
- digit_idx wraps only by explicit clear; it never exceeds NUM_DIGITS-1.
- Counters saturate by construction: fail_count resets before it can exceed MAX_TRIES.
- X/undefined states recover to ENTRY via the default branch.

Test Plan (DIGIT_W=4, NUM_DIGITS=3, CODE_INIT=12'h3A7, MAX_TRIES=3, LOCKOUT_CYCLES=8):
1. Correct entry: enter pulses with digit 3, A, 7 -> digit_idx 1,2,0; unlocked=1 one cycle after the third pulse; error stays 0; fail_count=0.
2. Wrong first digit: pulses 5, A, 7 -> no unlock after two pulses; error pulse exactly one cycle after the third; fail_count=1; state ENTRY, digit_idx=0.
3. Lockout: three wrong attempts (9 pulses) -> third evaluation gives error=1, fail_count=3, alarm=1 for exactly 8 cycles. Enter pulses during alarm are ignored. Afterwards alarm=0, fail_count=0, and a correct 3,A,7 unlocks.
4. Reprogram: unlock, hold set_code=1, pulse once to enter PROGRAM (unlocked stays 1), then pulses 1, 2, 4 -> OPEN. Relock with set_code=0 plus a pulse. Entry 3,A,7 fails; entry 1,2,4 unlocks.
5. Program abort: in PROGRAM after two digits (B, C), drop set_code -> returns to OPEN. Relock; old code 3,A,7 still unlocks.
6. Async reset mid-operation: assert Resetn=0 between clock edges during ALARM and again after reprogramming -> all outputs 0 immediately with no clock edge; code reverts so 3,A,7 unlocks.
